cnv_ctrl: RTL and testbench
===========================

# cnv_ctrl

Frame sequencer for the layer-0 3x3 convolution datapath. Loads the per-filter weights, raster-scans the image one pixel per cycle by driving `row`/`col`/`ctrl_data_run` into the convolution block, and honours back-pressure from the output writer. It counts the results returned on the datapath's `v_o`, generates a linear output address for each result, and signals frame completion. It sits between the layer top-level FSM (start/done) and the convolution datapath plus weight buffer.

## Interface
- `WIDTH`, default 320: image width in pixels.
- `HEIGHT`, default 320: image height in pixels.
- `NUM_FILT`, default 16: number of filters (MAC lanes) whose weights are loaded per frame.
- `ADDR_W`, default 17: output-address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT.
- `clk` (in, 1): sole clock.
- `rstn` (in, 1): synchronous, active-high reset. The codebase name is kept; despite the suffix, it is asserted high.
- `start_i` (in, 1): one-cycle frame start request.
- `stall_i` (in, 1): output writer back-pressure; blocks new pixel issue.
- `mac_vld_i` (in, 1): result-valid from the convolution datapath (`v_o`).
- `w_load_o` (out, 1): weight-buffer write strobe.
- `w_addr_o` (out, 5): filter index being loaded.
- `row_o`, `col_o` (out, 12 each): current pixel coordinate to the datapath.
- `ctrl_data_run_o` (out, 1): pixel at `row_o`/`col_o` is valid this cycle.
- `out_vld_o` (out, 1): registered copy of an accepted `mac_vld_i`.
- `out_addr_o` (out, ADDR_W): linear output address (row*WIDTH+col) of the result.
- `busy_o` (out, 1): high in every state other than IDLE.
- `frame_done_o` (out, 1): one-cycle pulse at frame end.

## Operation
- FSM states and transitions:
  - IDLE → LOAD_W on `start_i`.
  - LOAD_W → RUN after NUM_FILT cycles.
  - RUN → DRAIN after the last pixel is issued.
  - DRAIN → DONE when the result count reaches WIDTH*HEIGHT.
  - DONE → IDLE after one cycle.
- `start_i` outside IDLE is ignored.
- LOAD_W: `w_load_o`=1 and `w_addr_o` steps 0..NUM_FILT-1, one per cycle. `stall_i` has no effect here.
- RUN, stall low: issue (`row_o`,`col_o`) with `ctrl_data_run_o`=1. `col_o` advances each cycle; at WIDTH-1 it wraps to 0 and `row_o` increments.
- The pixel (HEIGHT-1, WIDTH-1) is issued exactly once, then the FSM enters DRAIN.
- RUN, stall high: `ctrl_data_run_o`=0 and `row_o`/`col_o` hold. Stall suppresses only issue. Results already in the MAC pipeline still arrive and must be absorbed by the writer.
- Result counter `out_cnt` increments on every `mac_vld_i` seen in RUN or DRAIN. `out_addr_o` equals `out_cnt` before the increment.
- `mac_vld_i` in IDLE, LOAD_W or DONE is dropped and not counted.
- DRAIN: no issue. Exit as soon as `out_cnt` == WIDTH*HEIGHT. This includes the case where the final result arrives in the same cycle the last pixel is issued plus latency, i.e. no extra wait.
- DONE: `frame_done_o`=1 for one cycle; all counters clear.
- Width rule: `out_cnt` is ADDR_W bits and never wraps within a frame.

## Timing
- All outputs are registered. Reset value of every output is 0, and the state is IDLE.
- `start_i` at cycle t gives `w_load_o`=1, `w_addr_o`=0 at t+1.
- The first pixel (0,0) with `ctrl_data_run_o`=1 appears at t+1+NUM_FILT.
- An unstalled frame issues WIDTH*HEIGHT pixels on consecutive cycles.
- `stall_i` sampled high at cycle c gives `ctrl_data_run_o`=0 at c+1.
- `mac_vld_i` at cycle c gives `out_vld_o`/`out_addr_o` at c+1.
- `frame_done_o` is asserted one cycle after the cycle in which the final result is counted.
- `rstn` asserted mid-frame: next cycle, all outputs are 0, the state is IDLE, and counters are cleared. In-flight results after reset are dropped.

## Configuration
- `CNV_CTRL_PERF_EN` defined: adds outputs `perf_cyc_o` and `perf_stall_o` (32 bits each).
  - `perf_cyc_o` counts cycles with `busy_o` high.
  - `perf_stall_o` counts RUN cycles with `stall_i` high.
  - Both clear on `start_i` accepted and hold their values after DONE.
- `CNV_CTRL_PERF_EN` not defined: the ports still exist but are tied to 0, and no counter logic is built.

## Structure
- Shared package `cnv_pkg` holds:
  - the state enum `cnv_state_t` (IDLE, LOAD_W, RUN, DRAIN, DONE);
  - the constants `CNV_WIDTH`, `CNV_HEIGHT` and `CNV_NUM_FILT`;
  - the coordinate width (12).
- One sub-module, `cnv_scan_cnt`: the row/col raster counter with enable, wrap and last-pixel flag. Everything else stays in `cnv_ctrl`.

## Test plan
- WIDTH=4, HEIGHT=3, NUM_FILT=2, no stall, datapath modelled as a fixed 3-cycle delay of `ctrl_data_run_o`:
  - `start_i` at cycle 0 → `w_addr_o` 0,1 at cycles 1–2;
  - pixels (0,0)…(2,3) at cycles 3–14;
  - `out_addr_o` 0…11 at cycles 7–18;
  - `frame_done_o` at cycle 19.
- Same setup, `stall_i` high for 3 cycles while `row_o`/`col_o` = (1,2):
  - `ctrl_data_run_o` low for 3 cycles and the coordinate holds;
  - `frame_done_o` arrives 3 cycles later than unstalled;
  - `perf_stall_o`=3 with the macro defined.
- `start_i` pulsed again during RUN → ignored; exactly 12 pixels are issued and exactly 1 `frame_done_o`.
- `mac_vld_i` pulsed in IDLE → no `out_vld_o`; on the next frame, `out_addr_o` still starts at 0.
- `rstn` high during DRAIN with 5 results outstanding → all outputs 0 the next cycle; late `mac_vld_i` is ignored; a new `start_i` runs a full correct frame.
- WIDTH=HEIGHT=1 → exactly one pixel (0,0) issued, `out_addr_o`=0, then `frame_done_o`.

Source files
------------

// File: rtl/cnv_pkg.sv
// rtl/cnv_pkg.sv - shared state type and constants for the layer-0 conv frame sequencer
package cnv_pkg;

    localparam int CNV_WIDTH    = 320;
    localparam int CNV_HEIGHT   = 320;
    localparam int CNV_NUM_FILT = 16;
    localparam int CNV_COORD_W  = 12;
    localparam int CNV_WADDR_W  = 5;

    typedef enum logic [2:0] {
        CNV_IDLE   = 3'd0,
        CNV_LOAD_W = 3'd1,
        CNV_RUN    = 3'd2,
        CNV_DRAIN  = 3'd3,
        CNV_DONE   = 3'd4
    } cnv_state_t;

endpackage

// File: rtl/cnv_if.sv
// rtl/cnv_if.sv - control, weight-load, pixel-issue and result signals of the conv sequencer
interface cnv_if #(
    parameter int ADDR_W = 17
);
    import cnv_pkg::*;

    logic                   start_i;
    logic                   stall_i;
    logic                   mac_vld_i;
    logic                   w_load_o;
    logic [CNV_WADDR_W-1:0] w_addr_o;
    logic [CNV_COORD_W-1:0] row_o;
    logic [CNV_COORD_W-1:0] col_o;
    logic                   ctrl_data_run_o;
    logic                   out_vld_o;
    logic [ADDR_W-1:0]      out_addr_o;
    logic                   busy_o;
    logic                   frame_done_o;
    logic [31:0]            perf_cyc_o;
    logic [31:0]            perf_stall_o;

    // sequencer side
    modport slave (
        input  start_i, stall_i, mac_vld_i,
        output w_load_o, w_addr_o, row_o, col_o, ctrl_data_run_o,
        output out_vld_o, out_addr_o, busy_o, frame_done_o,
        output perf_cyc_o, perf_stall_o
    );

    // layer FSM / datapath side
    modport master (
        output start_i, stall_i, mac_vld_i,
        input  w_load_o, w_addr_o, row_o, col_o, ctrl_data_run_o,
        input  out_vld_o, out_addr_o, busy_o, frame_done_o,
        input  perf_cyc_o, perf_stall_o
    );

endinterface

// File: rtl/cnv_scan_cnt.sv
// rtl/cnv_scan_cnt.sv - row/col raster counter with enable, wrap and last-pixel flag
module cnv_scan_cnt
    import cnv_pkg::*;
#(
    parameter int WIDTH  = CNV_WIDTH,
    parameter int HEIGHT = CNV_HEIGHT
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_en,
    output logic [CNV_COORD_W-1:0] o_row,
    output logic [CNV_COORD_W-1:0] o_col,
    output logic                   o_last
);

    localparam logic [CNV_COORD_W-1:0] LAST_COL = CNV_COORD_W'(WIDTH - 1);
    localparam logic [CNV_COORD_W-1:0] LAST_ROW = CNV_COORD_W'(HEIGHT - 1);
    localparam logic [CNV_COORD_W-1:0] ONE      = CNV_COORD_W'(1);

    logic [CNV_COORD_W-1:0] r_row;
    logic [CNV_COORD_W-1:0] r_col;
    logic                   w_col_end;
    logic                   w_last;

    assign w_col_end = (r_col == LAST_COL);
    assign w_last    = w_col_end && (r_row == LAST_ROW);

    // step one pixel per enabled cycle; after the last pixel return to the origin
    always_ff @(posedge clk) begin
        if (i_rst || i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_en) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_last ? '0 : r_row + ONE;
            end else begin
                r_col <= r_col + ONE;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_last;

endmodule

// File: rtl/cnv_ctrl.sv
// rtl/cnv_ctrl.sv - layer-0 conv frame sequencer; CNV_CTRL_PERF_EN adds busy/stall cycle counters
module cnv_ctrl
    import cnv_pkg::*;
#(
    parameter int WIDTH    = CNV_WIDTH,
    parameter int HEIGHT   = CNV_HEIGHT,
    parameter int NUM_FILT = CNV_NUM_FILT,
    parameter int ADDR_W   = 17
) (
    input logic  clk,
    input logic  rstn,
    cnv_if.slave bus
);

    localparam logic [2:0] S_IDLE   = CNV_IDLE;
    localparam logic [2:0] S_LOAD_W = CNV_LOAD_W;
    localparam logic [2:0] S_RUN    = CNV_RUN;
    localparam logic [2:0] S_DRAIN  = CNV_DRAIN;
    localparam logic [2:0] S_DONE   = CNV_DONE;

    localparam logic [CNV_WADDR_W-1:0] W_LAST  = CNV_WADDR_W'(NUM_FILT - 1);
    localparam logic [CNV_WADDR_W-1:0] W_ONE   = CNV_WADDR_W'(1);
    localparam logic [ADDR_W-1:0]      N_PIX   = ADDR_W'(WIDTH * HEIGHT);
    localparam logic [ADDR_W-1:0]      CNT_ONE = ADDR_W'(1);

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic                   r_w_load;
    logic [CNV_WADDR_W-1:0] r_w_addr;
    logic                   r_run;
    logic                   r_out_vld;
    logic [ADDR_W-1:0]      r_out_addr;
    logic [ADDR_W-1:0]      r_out_cnt;
    logic                   r_busy;
    logic                   r_done;

    logic [CNV_COORD_W-1:0] w_row;
    logic [CNV_COORD_W-1:0] w_col;
    logic                   w_last;
    logic                   w_issue;
    logic                   w_acc;
    logic                   w_run_nxt;
    logic                   w_scan_clr;

    // a pixel leaves only when RUN is presenting it with the run strobe up
    assign w_issue    = (r_state == S_RUN) && r_run;
    // results count only while a frame is in flight, and never past the frame size
    assign w_acc      = bus.mac_vld_i && ((r_state == S_RUN) || (r_state == S_DRAIN))
                        && (r_out_cnt != N_PIX);
    assign w_scan_clr = (r_state == S_DONE);

    cnv_scan_cnt #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_scan (
        .clk    (clk),
        .i_rst  (rstn),
        .i_clr  (w_scan_clr),
        .i_en   (w_issue),
        .o_row  (w_row),
        .o_col  (w_col),
        .o_last (w_last)
    );

    // next-state decision for the frame sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.start_i)              w_state_nxt = S_LOAD_W;
            S_LOAD_W: if (r_w_addr == W_LAST)       w_state_nxt = S_RUN;
            S_RUN:    if (w_issue && w_last)        w_state_nxt = S_DRAIN;
            S_DRAIN:  if (r_out_cnt == N_PIX)       w_state_nxt = S_DONE;
            S_DONE:                                 w_state_nxt = S_IDLE;
            default:                                w_state_nxt = S_IDLE;
        endcase
    end

    // the first RUN cycle always issues; afterwards a stall seen now blanks next cycle
    assign w_run_nxt = (w_state_nxt == S_RUN) && ((r_state == S_LOAD_W) || !bus.stall_i);

    // state and the registered control outputs derived from the next state
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state  <= S_IDLE;
            r_w_load <= 1'b0;
            r_w_addr <= '0;
            r_run    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_w_load <= (w_state_nxt == S_LOAD_W);
            r_w_addr <= ((r_state == S_LOAD_W) && (w_state_nxt == S_LOAD_W)) ? r_w_addr + W_ONE : '0;
            r_run    <= w_run_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= (w_state_nxt == S_DONE);
        end
    end

    // result counter and linear output address; cleared at frame end
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_out_vld  <= 1'b0;
            r_out_addr <= '0;
            r_out_cnt  <= '0;
        end else begin
            r_out_vld  <= w_acc;
            r_out_addr <= w_acc ? r_out_cnt : '0;
            if (r_state == S_DONE) begin
                r_out_cnt <= '0;
            end else if (w_acc) begin
                r_out_cnt <= r_out_cnt + CNT_ONE;
            end
        end
    end

`ifdef CNV_CTRL_PERF_EN
    logic [31:0] r_perf_cyc;
    logic [31:0] r_perf_stall;
    logic        w_start_acc;

    assign w_start_acc = (r_state == S_IDLE) && bus.start_i;

    // busy and RUN-stall cycle counters; restart with each accepted frame, hold afterwards
    always_ff @(posedge clk) begin
        if (rstn || w_start_acc) begin
            r_perf_cyc   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_busy) begin
                r_perf_cyc <= r_perf_cyc + 32'd1;
            end
            if ((r_state == S_RUN) && bus.stall_i) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign bus.perf_cyc_o   = r_perf_cyc;
    assign bus.perf_stall_o = r_perf_stall;
`else
    assign bus.perf_cyc_o   = '0;
    assign bus.perf_stall_o = '0;
`endif

    assign bus.w_load_o        = r_w_load;
    assign bus.w_addr_o        = r_w_addr;
    assign bus.row_o           = w_row;
    assign bus.col_o           = w_col;
    assign bus.ctrl_data_run_o = r_run;
    assign bus.out_vld_o       = r_out_vld;
    assign bus.out_addr_o      = r_out_addr;
    assign bus.busy_o          = r_busy;
    assign bus.frame_done_o    = r_done;

endmodule

// File: tb/tb_cnv_ctrl.sv
// tb/tb_cnv_ctrl.sv - self-checking bench for cnv_ctrl (4x3 and 1x1 frames)
module tb_cnv_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int NF = 2;
    localparam int N  = W * H;
    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dly = '0;
    logic [2:0]  tdly = '0;
    logic        inj_vld = 1'b0;
    int          lat = 3;
    int          n_chk = 0;
    int          n_fail = 0;
    int          outs;
    int          k;

    cnv_if #(.ADDR_W(AW)) m_if ();
    cnv_if #(.ADDR_W(2))  t_if ();

    cnv_ctrl #(.WIDTH(W), .HEIGHT(H), .NUM_FILT(NF), .ADDR_W(AW)) u_dut (
        .clk  (clk),
        .rstn (rst),
        .bus  (m_if)
    );

    cnv_ctrl #(.WIDTH(1), .HEIGHT(1), .NUM_FILT(1), .ADDR_W(2)) u_tiny (
        .clk  (clk),
        .rstn (rst),
        .bus  (t_if)
    );

    always #5 clk = ~clk;

    // datapath stand-ins: fixed-latency echo of the run strobe
    always @(posedge clk) begin
        dly  <= {dly[14:0], m_if.ctrl_data_run_o};
        tdly <= {tdly[1:0], t_if.ctrl_data_run_o};
    end
    assign m_if.mac_vld_i = dly[lat-1] | inj_vld;
    assign t_if.mac_vld_i = tdly[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wload"}, 32'(m_if.w_load_o), 0);
        chk({tag, "_waddr"}, 32'(m_if.w_addr_o), 0);
        chk({tag, "_row"},   32'(m_if.row_o), 0);
        chk({tag, "_col"},   32'(m_if.col_o), 0);
        chk({tag, "_run"},   32'(m_if.ctrl_data_run_o), 0);
        chk({tag, "_ovld"},  32'(m_if.out_vld_o), 0);
        chk({tag, "_oaddr"}, 32'(m_if.out_addr_o), 0);
        chk({tag, "_busy"},  32'(m_if.busy_o), 0);
        chk({tag, "_done"},  32'(m_if.frame_done_o), 0);
    endtask

    // one frame on the 4x3 DUT; smode 0 none, 1 three-cycle stall at (1,2), 2 random
    task automatic frame(input int lat_v, input int smode, input bit poke, input int exp_done_rel);
        int rel, issued, nout, exp_stall, last_out, stall_left, done_rel, exp_done_cyc;
        bit prev_stall, prev_mac, seen_done, in_run, exp_run, exp_ov, exp_done, s;
        lat = lat_v;
        issued = 0; nout = 0; exp_stall = 0; last_out = -10; stall_left = 0;
        done_rel = -1; exp_done_cyc = -1; prev_stall = 0; seen_done = 0;
        @(negedge clk);
        m_if.start_i = 1'b1;
        m_if.stall_i = 1'b0;
        prev_mac = m_if.mac_vld_i;
        rel = 0;
        while (!seen_done && rel < 500) begin
            @(negedge clk);
            rel++;
            m_if.start_i = 1'b0;
            chk("w_load", 32'(m_if.w_load_o), 32'(rel <= NF));
            chk("w_addr", 32'(m_if.w_addr_o), (rel <= NF) ? rel - 1 : 0);
            in_run = (rel > NF) && (issued < N);
            if (issued >= N)     exp_run = 1'b0;
            else if (issued == 0) exp_run = (rel == NF + 1);
            else                 exp_run = !prev_stall;
            chk("run", 32'(m_if.ctrl_data_run_o), 32'(exp_run));
            if (in_run) begin
                chk("row", 32'(m_if.row_o), issued / W);
                chk("col", 32'(m_if.col_o), issued % W);
            end
            if (m_if.ctrl_data_run_o) issued++;
            exp_ov = prev_mac && (nout < N);
            chk("out_vld", 32'(m_if.out_vld_o), 32'(exp_ov));
            if (m_if.out_vld_o) begin
                chk("out_addr", 32'(m_if.out_addr_o), nout);
                nout++;
                last_out = rel;
            end
            exp_done = (nout == N) && (rel == last_out + 1);
            chk("frame_done", 32'(m_if.frame_done_o), 32'(exp_done));
            chk("busy", 32'(m_if.busy_o), 1);
            if (m_if.frame_done_o && done_rel < 0) done_rel = rel;
            if (exp_done) begin
                seen_done = 1'b1;
                exp_done_cyc = rel;
            end
            prev_mac = m_if.mac_vld_i;
            if (smode == 1 && m_if.ctrl_data_run_o && issued == W + 2) stall_left = 3;
            case (smode)
                1:       begin s = (stall_left > 0); if (stall_left > 0) stall_left--; end
                2:       s = ($urandom_range(0, 2) == 0);
                default: s = 1'b0;
            endcase
            if (in_run && s) exp_stall++;
            m_if.stall_i = s;
            prev_stall = s;
            m_if.start_i = poke && (issued == 5);
        end
        if (!seen_done) chk("frame_timeout", 0, 1);
        chk("pix_count", issued, N);
        if (exp_done_rel >= 0) chk("done_cycle", done_rel, exp_done_rel);
        m_if.stall_i = 1'b0;
        m_if.start_i = 1'b0;
        @(negedge clk);
`ifdef CNV_CTRL_PERF_EN
        chk("perf_cyc", m_if.perf_cyc_o, exp_done_cyc);
        chk("perf_stall", m_if.perf_stall_o, exp_stall);
        if (smode == 1) chk("perf_stall_dir", m_if.perf_stall_o, 3);
`else
        chk("perf_cyc_tied", m_if.perf_cyc_o, 0);
        chk("perf_stall_tied", m_if.perf_stall_o, 0);
`endif
        for (int i = 0; i < 4; i++) begin
            chk("post_busy", 32'(m_if.busy_o), 0);
            chk("post_done", 32'(m_if.frame_done_o), 0);
            chk("post_wload", 32'(m_if.w_load_o), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        m_if.start_i = 1'b0;
        m_if.stall_i = 1'b0;
        t_if.start_i = 1'b0;
        t_if.stall_i = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_tiny_busy", 32'(t_if.busy_o), 0);
        rst = 1'b0;
        @(negedge clk);

        frame(3, 0, 0, 19);
        frame(3, 1, 0, 22);
        frame(3, 0, 1, 19);

        inj_vld = 1'b1;
        @(negedge clk);
        inj_vld = 1'b0;
        chk("idle_vld_dropped", 32'(m_if.out_vld_o), 0);
        chk("idle_addr", 32'(m_if.out_addr_o), 0);
        @(negedge clk);
        frame(3, 0, 0, 19);

        lat = 8;
        @(negedge clk);
        m_if.start_i = 1'b1;
        outs = 0;
        k = 0;
        while (outs < N - 5 && k < 100) begin
            @(negedge clk);
            m_if.start_i = 1'b0;
            if (m_if.out_vld_o) outs++;
            k++;
        end
        chk("drain_reached", outs, N - 5);
        chk("drain_busy", 32'(m_if.busy_o), 1);
        chk("drain_run", 32'(m_if.ctrl_data_run_o), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("midrst");
        chk("midrst_perf_cyc", m_if.perf_cyc_o, 0);
        chk("midrst_perf_stall", m_if.perf_stall_o, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("late_vld_dropped", 32'(m_if.out_vld_o), 0);
            chk("late_busy", 32'(m_if.busy_o), 0);
        end
        frame(3, 0, 0, 19);

        for (int i = 0; i < 5; i++) frame($urandom_range(1, 6), 2, 0, -1);

        @(negedge clk);
        t_if.start_i = 1'b1;
        for (int r = 1; r <= 10; r++) begin
            @(negedge clk);
            t_if.start_i = 1'b0;
            chk("tiny_run", 32'(t_if.ctrl_data_run_o), 32'(r == 2));
            chk("tiny_row", 32'(t_if.row_o), 0);
            chk("tiny_col", 32'(t_if.col_o), 0);
            chk("tiny_out_vld", 32'(t_if.out_vld_o), 32'(r == 6));
            chk("tiny_out_addr", 32'(t_if.out_addr_o), 0);
            chk("tiny_done", 32'(t_if.frame_done_o), 32'(r == 7));
            chk("tiny_busy", 32'(t_if.busy_o), 32'(r <= 7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
